multi_phase_traffic_controller: RTL

- Parametrised successor to the two-approach traffic controller.
- Serves N_APPROACHES approaches in round-robin order with actuated green: green runs between a minimum and maximum time, and approaches with no demand are skipped.
- Each green ends with a yellow interval and then an all-red clearance interval.
- Supports directed emergency preemption toward any approach.
- Sits at the top of the intersection datapath; drives lamp outputs and a countdown for the display/debug bus.

---
 rtl/multi_phase_traffic_controller_pkg.sv | 20 ++
 rtl/multi_phase_traffic_controller_rr_next_phase.sv | 25 ++
 rtl/multi_phase_traffic_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_phase_traffic_controller_pkg.sv
// Shared types and constants for the multi-approach traffic controller.
// WALK is only reachable when PED_WALK_EN is defined.
package traffic_pkg;

    typedef enum logic [2:0] {
        GREEN   = 3'd0,
        YELLOW  = 3'd1,
        ALL_RED = 3'd2,
        EMERG   = 3'd3,
        WALK    = 3'd4
    } state_t;

    localparam int G_OFS = 0;
    localparam int Y_OFS = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_phase_traffic_controller_rr_next_phase.sv
// Cyclic priority search over approach demand, starting just after the current phase.
module rr_next_phase
    import traffic_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_dem,
    input  logic [IW-1:0] i_phase,
    output logic [IW-1:0] o_next,
    output logic          o_found
);

    // The nearest demanding approach wins; the current phase itself is tried last.
    always_comb begin
        o_next  = i_phase;
        o_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            o_next  = (!o_found && i_dem[(int'(i_phase) + k) % N])
                      ? IW'((int'(i_phase) + k) % N) : o_next;
            o_found = o_found | i_dem[(int'(i_phase) + k) % N];
        end
    end

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// Round-robin actuated traffic controller with directed emergency preemption.
// Define PED_WALK_EN to add the pedestrian walk interval (ped_req / walk ports).
module multi_phase_traffic_controller
    import traffic_pkg::*;
#(
    parameter  int N_APPROACHES = 2,
    parameter  int TIMER_W      = 8,
    parameter  int G_MIN        = 20,
    parameter  int G_MAX        = 100,
    parameter  int Y_TIME       = 20,
    parameter  int R_TIME       = 5,
`ifdef PED_WALK_EN
    parameter  int W_TIME       = 30,
`endif
    localparam int IDX_W        = idx_w(N_APPROACHES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        emergency,
    input  logic [IDX_W-1:0]            emergency_dir,
    input  logic [2*N_APPROACHES-1:0]   traffic_sensors,
`ifdef PED_WALK_EN
    input  logic                        ped_req,
    output logic                        walk,
`endif
    output logic [2*N_APPROACHES-1:0]   light,
    output logic [TIMER_W-1:0]          state_timer_out,
    output logic [IDX_W-1:0]            current_phase
);

`ifdef PED_WALK_EN
    localparam int W_DUR = W_TIME;
`else
    localparam int W_DUR = 1;
`endif
    localparam int T_MAX = (1 << TIMER_W) - 1;
    localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] T_GAP = TIMER_W'(G_MAX - G_MIN + 1);
    localparam logic [2*N_APPROACHES-1:0] LIGHT_RST = {{(2*N_APPROACHES-1){1'b0}}, 1'b1};

    if (N_APPROACHES < 2 || N_APPROACHES > 8 || G_MIN < 1 || G_MAX < G_MIN ||
        Y_TIME < 1 || R_TIME < 1 || W_DUR < 1 || G_MAX > T_MAX || Y_TIME > T_MAX ||
        R_TIME > T_MAX || W_DUR > T_MAX) begin : g_param_err
        $error("multi_phase_traffic_controller: illegal parameter combination");
    end

    state_t                      r_state;
    logic [IDX_W-1:0]            r_phase;
    logic [TIMER_W-1:0]          r_timer;
    logic [2*N_APPROACHES-1:0]   r_light;
    state_t                      w_nxt_state;
    logic [IDX_W-1:0]            w_nxt_phase;
    logic [TIMER_W-1:0]          w_nxt_timer;
    logic [2*N_APPROACHES-1:0]   w_nxt_light;
    logic [TIMER_W-1:0]          w_dec;
    logic [N_APPROACHES-1:0]     w_dem;
    logic                        w_other;
    logic [IDX_W-1:0]            w_rr_next;
    logic                        w_rr_found;
`ifdef PED_WALK_EN
    logic                        r_ped_latch;
    logic                        r_walk;
`endif

    // Per-approach demand: either detector of the approach active this cycle.
    always_comb begin
        w_dem = '0;
        for (int i = 0; i < N_APPROACHES; i++) begin
            w_dem[i] = |traffic_sensors[2*i +: 2];
        end
    end

    assign w_other = |(w_dem & ~(N_APPROACHES'(1) << r_phase));
    assign w_dec   = (r_timer > T_ONE) ? (r_timer - T_ONE) : T_ONE;

    rr_next_phase #(.N(N_APPROACHES)) u_rr (
        .i_dem   (w_dem),
        .i_phase (r_phase),
        .o_next  (w_rr_next),
        .o_found (w_rr_found)
    );

    // Next-state logic; emergency is evaluated before any timing rule.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_timer = w_dec;
        case (r_state)
            GREEN: begin
                if (emergency && (emergency_dir == r_phase)) begin
                    w_nxt_state = EMERG;
                    w_nxt_timer = '0;
                end else if (emergency || (w_other && ((!w_dem[r_phase] && r_timer <= T_GAP) ||
                                                       r_timer == T_ONE))) begin
                    w_nxt_state = YELLOW;
                    w_nxt_timer = TIMER_W'(Y_TIME);
                end else begin
                    w_nxt_timer = w_dec;
                end
            end
            YELLOW: begin
                if (r_timer == T_ONE) begin
                    w_nxt_state = ALL_RED;
                    w_nxt_timer = TIMER_W'(R_TIME);
                end else begin
                    w_nxt_timer = w_dec;
                end
            end
            ALL_RED: begin
                if (r_timer == T_ONE) begin
                    if (emergency) begin
                        w_nxt_state = EMERG;
                        w_nxt_phase = emergency_dir;
                        w_nxt_timer = '0;
`ifdef PED_WALK_EN
                    end else if (r_ped_latch) begin
                        w_nxt_state = WALK;
                        w_nxt_timer = TIMER_W'(W_DUR);
`endif
                    end else begin
                        w_nxt_state = GREEN;
                        w_nxt_phase = w_rr_found ? w_rr_next : r_phase;
                        w_nxt_timer = TIMER_W'(G_MAX);
                    end
                end else begin
                    w_nxt_timer = w_dec;
                end
            end
            EMERG: begin
                if (!emergency) begin
                    w_nxt_state = GREEN;
                    w_nxt_timer = TIMER_W'(G_MAX);
                end else if (emergency_dir != r_phase) begin
                    w_nxt_state = YELLOW;
                    w_nxt_timer = TIMER_W'(Y_TIME);
                end else begin
                    w_nxt_timer = '0;
                end
            end
`ifdef PED_WALK_EN
            WALK: begin
                if (emergency) begin
                    w_nxt_state = ALL_RED;
                    w_nxt_timer = TIMER_W'(R_TIME);
                end else if (r_timer == T_ONE) begin
                    w_nxt_state = GREEN;
                    w_nxt_phase = w_rr_found ? w_rr_next : r_phase;
                    w_nxt_timer = TIMER_W'(G_MAX);
                end else begin
                    w_nxt_timer = w_dec;
                end
            end
`endif
            default: begin
                w_nxt_state = GREEN;
                w_nxt_phase = '0;
                w_nxt_timer = TIMER_W'(G_MAX);
            end
        endcase
    end

    // Lamp pattern for the state being entered, so lamps line up with the state register.
    always_comb begin
        w_nxt_light = '0;
        case (w_nxt_state)
            GREEN, EMERG: w_nxt_light[2*int'(w_nxt_phase) + G_OFS] = 1'b1;
            YELLOW:       w_nxt_light[2*int'(w_nxt_phase) + Y_OFS] = 1'b1;
            default:      w_nxt_light = '0;
        endcase
    end

    // State, timer and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= GREEN;
            r_phase <= '0;
            r_timer <= TIMER_W'(G_MAX);
            r_light <= LIGHT_RST;
`ifdef PED_WALK_EN
            r_ped_latch <= 1'b0;
            r_walk      <= 1'b0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
            r_timer <= w_nxt_timer;
            r_light <= w_nxt_light;
`ifdef PED_WALK_EN
            r_ped_latch <= (w_nxt_state == WALK && r_state != WALK) ? 1'b0 : (r_ped_latch | ped_req);
            r_walk      <= (w_nxt_state == WALK);
`endif
        end
    end

    assign light           = r_light;
    assign state_timer_out = r_timer;
    assign current_phase   = r_phase;
`ifdef PED_WALK_EN
    assign walk            = r_walk;
`endif

endmodule
